// File: rtl/ws_rx_pkg.sv
// Shared types, timing defaults and helpers for the WS2812 receive path.
// Build option: WS_RX_GLITCH_FILTER_EN enables the 3-sample input majority filter.
package ws_rx_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  // Nominal line timings, also used by the LED serializer.
  localparam int DEF_SYS_FREQ_MHZ = 100;
  localparam int DEF_THRESH_NS    = 625;
  localparam int DEF_MAX_HIGH_NS  = 1250;
  localparam int DEF_RESET_NS     = 50000;
  localparam int DEF_MAX_PIXELS   = 64;
  localparam int DEF_T1H_NS       = 800;
  localparam int DEF_T1L_NS       = 450;
  localparam int DEF_T0H_NS       = 400;
  localparam int DEF_T0L_NS       = 850;

  function automatic int ns_to_cyc(input int ns, input int freq_mhz);
    return (ns * freq_mhz) / 1000;
  endfunction

endpackage

// File: rtl/ws_rx_edge_sync.sv
// Synchronizes raw din into clk, optionally majority-filters it, and emits edge strobes.
// Build option: WS_RX_GLITCH_FILTER_EN adds the 3-sample majority filter (+2 cycles latency).
module ws_rx_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

`ifdef WS_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;

  // Two of three samples must agree, so a single-cycle pulse never reaches level.
  always_comb begin
    hist_d = {hist_q[0], sync_q[1]};
    filt_d = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/ws2812_stream_decoder.sv
// Decodes a WS2812 NRZ pulse-width stream into 24-bit GRB pixels with frame and error reporting.
// Build option: WS_RX_GLITCH_FILTER_EN (see ws_rx_edge_sync) adds 2 cycles to every latency.
module ws2812_stream_decoder
  import ws_rx_pkg::*;
#(
  parameter int SYS_FREQ_MHZ = DEF_SYS_FREQ_MHZ,
  parameter int THRESH_NS    = DEF_THRESH_NS,
  parameter int MAX_HIGH_NS  = DEF_MAX_HIGH_NS,
  parameter int RESET_NS     = DEF_RESET_NS,
  parameter int MAX_PIXELS   = DEF_MAX_PIXELS,
  parameter int IW           = $clog2(MAX_PIXELS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          din,
  output logic [23:0]   pixel_data,
  output logic          pixel_valid,
  output logic [IW-1:0] pixel_index,
  output logic          frame_done,
  output logic [IW:0]   frame_pixels,
  output logic          err,
  input  logic          err_clr,
  output state_e        dbg_state
);

  localparam int THRESH_CYC   = ns_to_cyc(THRESH_NS, SYS_FREQ_MHZ);
  localparam int MAX_HIGH_CYC = ns_to_cyc(MAX_HIGH_NS, SYS_FREQ_MHZ);
  localparam int RESET_CYC    = ns_to_cyc(RESET_NS, SYS_FREQ_MHZ);
  localparam int HCW          = $clog2(MAX_HIGH_CYC + 2);
  localparam int LCW          = $clog2(RESET_CYC + 1);
  localparam int PW           = IW + 1;

  localparam logic [HCW-1:0] THRESH_C = HCW'(THRESH_CYC);
  localparam logic [HCW-1:0] MAXH_C   = HCW'(MAX_HIGH_CYC);
  localparam logic [LCW-1:0] RESET_C  = LCW'(RESET_CYC);
  localparam logic [LCW-1:0] RESET_M1 = LCW'(RESET_CYC - 1);
  localparam logic [PW-1:0]  PIX_MAX  = PW'(MAX_PIXELS);

  logic level, rise, fall;

  ws_rx_edge_sync u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  state_e          state_q, state_d;
  logic [HCW-1:0]  high_cnt_q, high_cnt_d;
  logic [LCW-1:0]  low_cnt_q, low_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [PW-1:0]   pixel_cnt_q, pixel_cnt_d;
  grb_t            pixel_data_q, pixel_data_d;
  logic            pixel_valid_q, pixel_valid_d;
  logic [IW-1:0]   pixel_index_q, pixel_index_d;
  logic            frame_done_q, frame_done_d;
  logic [IW:0]     frame_pixels_q, frame_pixels_d;
  logic            err_q, err_d;
  logic            err_set;
  logic            bit_val;
  logic [23:0]     new_word;

  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    low_cnt_d      = low_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    pixel_cnt_d    = pixel_cnt_q;
    pixel_data_d   = pixel_data_q;
    pixel_valid_d  = 1'b0;
    pixel_index_d  = pixel_index_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_set        = 1'b0;
    bit_val        = (high_cnt_q >= THRESH_C);
    new_word       = {shift_q[22:0], bit_val};

    case (state_q)
      SYNC: begin
        if (level) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == RESET_M1) begin
          // Arrive in LOW with the count already saturated so arming never reports a frame.
          low_cnt_d = RESET_C;
          state_d   = LOW;
        end else begin
          low_cnt_d = low_cnt_q + LCW'(1);
        end
      end

      LOW: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = HCW'(1);
        end else if (low_cnt_q != RESET_C) begin
          low_cnt_d = low_cnt_q + LCW'(1);
          if (low_cnt_q == RESET_M1) begin
            if ((pixel_cnt_q != '0) || (bit_cnt_q != '0)) begin
              frame_done_d   = 1'b1;
              frame_pixels_d = pixel_cnt_q;
              pixel_cnt_d    = '0;
              pixel_index_d  = '0;
            end
            if (bit_cnt_q != '0) begin
              err_set   = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
      end

      HIGH: begin
        if (high_cnt_q > MAXH_C) begin
          err_set     = 1'b1;
          bit_cnt_d   = '0;
          pixel_cnt_d = '0;
          low_cnt_d   = '0;
          state_d     = SYNC;
        end else if (fall) begin
          state_d   = LOW;
          low_cnt_d = LCW'(1);
          shift_d   = new_word;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (pixel_cnt_q != PIX_MAX) begin
              pixel_valid_d = 1'b1;
              pixel_data_d  = grb_t'(new_word);
              pixel_index_d = pixel_cnt_q[IW-1:0];
              pixel_cnt_d   = pixel_cnt_q + PW'(1);
            end else begin
              err_set = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          high_cnt_d = high_cnt_q + HCW'(1);
        end
      end

      default: state_d = SYNC;
    endcase

    // A new error in the same cycle as err_clr keeps the flag set.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SYNC;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      pixel_cnt_q    <= '0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_index_q  <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      pixel_cnt_q    <= pixel_cnt_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_index_q  <= pixel_index_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
    end
  end

  assign pixel_data   = pixel_data_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel_index  = pixel_index_q;
  assign frame_done   = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ws2812_stream_decoder.sv
// Self-checking bench for ws2812_stream_decoder against a bit-list frame model.
module tb_ws2812_stream_decoder;
  import ws_rx_pkg::*;

  localparam int THRESH_CYC = 625 * 100 / 1000;
  localparam int RESET_CYC  = 50000 * 100 / 1000;
  localparam int MAX_PIX    = 64;
  localparam int GAP        = RESET_CYC + 20;
`ifdef WS_RX_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset_n;
  logic        din;
  logic        err_clr;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [5:0]  pixel_index;
  logic        frame_done;
  logic [6:0]  frame_pixels;
  logic        err;
  state_e      dbg_state;

  ws2812_stream_decoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_index  (pixel_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .err          (err),
    .err_clr      (err_clr),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [23:0] got_data_q[$];
  logic [5:0]  got_idx_q[$];
  logic [31:0] got_cyc_q[$];
  int          fd_cnt = 0;
  logic [6:0]  fd_fp  = '0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      got_data_q.push_back(pixel_data);
      got_idx_q.push_back(pixel_index);
      got_cyc_q.push_back(32'(cyc));
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_fp  <= frame_pixels;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [23:0] exp_q[$];
  logic [5:0]  exp_idx_q[$];
  logic [31:0] exp_cyc_q[$];
  bit          mq[$];
  bit          m_armed = 1'b0;
  int          m_pix   = 0;
  bit          m_err   = 1'b0;
  int          m_fd    = 0;
  int          m_fp    = 0;
  logic [23:0] m_last  = '0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_bit(input bit b, input int fall_cyc);
    logic [23:0] w;
    if (!m_armed) return;
    mq.push_back(b);
    if (mq.size() == 24) begin
      w = '0;
      foreach (mq[i]) w = {w[22:0], mq[i]};
      if (m_pix < MAX_PIX) begin
        exp_q.push_back(w);
        exp_idx_q.push_back(6'(m_pix));
        exp_cyc_q.push_back(32'(fall_cyc + LAT));
        m_last = w;
        m_pix++;
      end else begin
        m_err = 1'b1;
      end
      mq.delete();
    end
  endtask

  task automatic model_gap();
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_pix > 0 || mq.size() > 0) begin
      m_fd++;
      m_fp = m_pix;
      if (mq.size() > 0) m_err = 1'b1;
      m_pix = 0;
      mq.delete();
    end
  endtask

  task automatic model_overflow();
    m_err   = 1'b1;
    m_armed = 1'b0;
    m_pix   = 0;
    mq.delete();
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, 32'(got_data_q.size()), 32'(exp_q.size()));
    while (got_data_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_data"}, 32'(got_data_q.pop_front()), 32'(exp_q.pop_front()));
      check({tag, "_idx"},  32'(got_idx_q.pop_front()),  32'(exp_idx_q.pop_front()));
      check({tag, "_lat"},  got_cyc_q.pop_front(),       exp_cyc_q.pop_front());
    end
    got_data_q.delete(); got_idx_q.delete(); got_cyc_q.delete();
    exp_q.delete(); exp_idx_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_fd_cnt"}, 32'(fd_cnt), 32'(m_fd));
    check({tag, "_fp"},     32'(fd_fp),  32'(m_fp));
    check({tag, "_err"},    32'(err),    32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    model_bit(hi >= THRESH_CYC, cyc);
    repeat (lo) @(negedge clk);
  endtask

  // mode 0: nominal 80/45 and 40/85; mode 1: fast; mode 2: threshold edge 62 vs 61
  task automatic send_pixel(input logic [23:0] d, input int mode);
    for (int i = 23; i >= 0; i--) begin
      case (mode)
        0:       send_bit(d[i] ? 80 : 40, d[i] ? 45 : 85);
        1:       send_bit(d[i] ? 65 : 9, 3);
        default: send_bit(d[i] ? 62 : 61, 3);
      endcase
    end
  endtask

  task automatic gap();
    idle(GAP);
    model_gap();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] rnd;
    reset_n = 1'b0;
    din     = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",   32'(pixel_data),   32'h0);
    check("rst_valid",  32'(pixel_valid),  32'h0);
    check("rst_index",  32'(pixel_index),  32'h0);
    check("rst_fdone",  32'(frame_done),   32'h0);
    check("rst_fpix",   32'(frame_pixels), 32'h0);
    check("rst_err",    32'(err),          32'h0);
    check("rst_state",  32'(dbg_state),    32'(SYNC));
    reset_n = 1'b1;
    @(negedge clk);

    // Arm, then a nominal-timing pixel.
    gap();
    check("arm_fd_cnt", 32'(fd_cnt), 32'(m_fd));
    check("arm_state",  32'(dbg_state), 32'(LOW));
    send_pixel(24'hFF00FF, 0);
    idle(10);
    drain("p0");
    check("p0_fd_cnt", 32'(fd_cnt), 32'(m_fd));
    check("p0_err",    32'(err),    32'(m_err));

    // Threshold boundary, then a 12-bit partial pixel closes the frame with an error.
    send_pixel(24'hAAAAAA, 2);
    send_pixel(24'h555555, 2);
    idle(10);
    drain("thr");
    check("thr_hold", 32'(pixel_data), 32'(m_last));
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) send_bit(65, 3);
      else                           send_bit(9, 3);
    end
    gap();
    drain("part");
    check_frame("part");
    clear_err();
    check("part_errclr", 32'(err), 32'(m_err));

    // Full frame plus one extra pixel past the limit.
    for (int i = 0; i <= MAX_PIX; i++) begin
      rnd = 24'(i * 32'h010101);
      send_pixel(rnd, 1);
    end
    gap();
    drain("full");
    check_frame("full");
    clear_err();

    // Next frame restarts at index 0; then a spike inside a low period.
    rnd = 24'($urandom);
    send_pixel(rnd, 1);
    idle(10);
    drain("restart");
    rnd = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      din = 1'b1;
      repeat (rnd[i] ? 80 : 40) @(negedge clk);
      din = 1'b0;
      model_bit(rnd[i], cyc);
      repeat (40) @(negedge clk);
      if (i == 12) begin
        din = 1'b1;
        @(negedge clk);
        din = 1'b0;
        if (!FILT) model_bit(1'b0, cyc);
      end
      repeat (rnd[i] ? 5 : 45) @(negedge clk);
    end
    idle(10);
    drain("spike");
    check("spike_err", 32'(err), 32'(m_err));

    // Over-long high pulse drops to SYNC; bits are ignored until a fresh gap.
    din = 1'b1;
    repeat (130) @(negedge clk);
    din = 1'b0;
    model_overflow();
    idle(10);
    check("ovf_err",   32'(err),       32'(m_err));
    check("ovf_state", 32'(dbg_state), 32'(SYNC));
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) send_bit(65, 3);
      else                           send_bit(9, 3);
    end
    gap();
    drain("ignored");
    check("ignored_fd_cnt", 32'(fd_cnt), 32'(m_fd));
    check("rearm_state",    32'(dbg_state), 32'(LOW));
    rnd = 24'($urandom);
    send_pixel(rnd, 1);
    idle(10);
    drain("resume");
    check("resume_err", 32'(err), 32'(m_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
